mult_pipe: RTL and testbench



---
 rtl/mult_pipe_pkg.sv | 40 ++++
 rtl/mult_pipe_stage.sv | 51 +++++
 rtl/mult_pipe.sv | 95 +++++++++
 tb/tb_mult_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pipe_pkg.sv
// Shared constants and range helpers for the multiplier pipeline.
// Latency: n/a (package only).
// Backpressure: n/a.
package mult_pipe_pkg;

    localparam int PIPE_DEPTH_MAX = 4;
    // Widest exact product: (32+1) x (32+1) bits.
    localparam int FULL_W = 66;

    // True when value lies inside the width-bit signed (or unsigned) range.
    function automatic logic prod_fits(input logic signed [FULL_W-1:0] value,
                                       input int width,
                                       input logic signed_range);
        logic signed [FULL_W-1:0] hi;
        if (signed_range) begin
            // Every bit from width-1 upward must be a copy of the sign.
            hi = value >>> (width - 1);
            return (hi == '0) || (hi == '1);
        end
        hi = value >>> width;
        return (hi == '0);
    endfunction

    // Saturation value for a result of the given sign, in the low width bits.
    function automatic logic [63:0] sat_limit(input logic sign,
                                              input int width,
                                              input logic signed_range);
        logic [63:0] top_bit;
        top_bit = 64'd1 << (width - 1);
        if (!signed_range) begin
            // At width 64 the shift wraps to zero and the subtract gives all-ones.
            return (top_bit << 1) - 64'd1;
        end
        if (sign) begin
            return top_bit;
        end
        return top_bit - 64'd1;
    endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One pipeline register holding {product, overflow, valid}.
// Latency: 1 enabled cycle.
// Backpressure: ce_i=0 holds contents; rst clears regardless of ce_i.
module mult_pipe_stage #(
    parameter int P_W = 48
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce_i,
    input  logic [P_W-1:0] prod_i,
    input  logic           ovf_i,
    input  logic           vld_i,
    output logic [P_W-1:0] prod_o,
    output logic           ovf_o,
    output logic           vld_o
);

    logic [P_W-1:0] prod_q, prod_d;
    logic           ovf_q,  ovf_d;
    logic           vld_q,  vld_d;

    // Next state: load when enabled, otherwise hold.
    always_comb begin
        prod_d = prod_q;
        ovf_d  = ovf_q;
        vld_d  = vld_q;
        if (ce_i) begin
            prod_d = prod_i;
            ovf_d  = ovf_i;
            vld_d  = vld_i;
        end
    end

    // Stage register; reset wins over a held stage so in-flight work is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
        end
    end

    assign prod_o = prod_q;
    assign ovf_o  = ovf_q;
    assign vld_o  = vld_q;

endmodule

// File: rtl/mult_pipe.sv
// Signed/unsigned multiplier with resize/saturate and a PIPE_DEPTH-stage valid pipeline.
// Latency: PIPE_DEPTH enabled cycles (0 = combinational).
// Backpressure: none beyond CEM; CEM=0 freezes every stage together.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int A_W        = 25,
    parameter int B_W        = 18,
    parameter int P_W        = 48,
    parameter int PIPE_DEPTH = 1,
    parameter int SAT        = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           CEM,
    input  logic           USE_MULT,
    input  logic           A_SIGNED,
    input  logic           B_SIGNED,
    input  logic           IN_VALID,
    input  logic [A_W-1:0] AMULT,
    input  logic [B_W-1:0] BMULT,
    output logic [P_W-1:0] M,
    output logic           M_VALID,
    output logic           M_OVF
);

    localparam int PROD_W = A_W + B_W + 2;

    if (PIPE_DEPTH < 0 || PIPE_DEPTH > PIPE_DEPTH_MAX ||
        A_W < 2 || A_W > 32 || B_W < 2 || B_W > 32 ||
        P_W < 2 || P_W > 64) begin : g_param_check
        $error("mult_pipe: parameter out of range");
    end

    // One extra bit per operand lets a single signed multiply cover all four modes.
    logic signed [A_W:0]        a_ext;
    logic signed [B_W:0]        b_ext;
    logic signed [PROD_W-1:0]   prod_full;
    logic signed [FULL_W-1:0]   prod_x;
    logic                       signed_rng;

    assign a_ext      = $signed({A_SIGNED & AMULT[A_W-1], AMULT});
    assign b_ext      = $signed({B_SIGNED & BMULT[B_W-1], BMULT});
    assign prod_full  = a_ext * b_ext;
    assign prod_x     = FULL_W'(prod_full);
    assign signed_rng = A_SIGNED | B_SIGNED;

    logic [P_W-1:0] in_prod;
    logic           in_ovf;
    logic           fits;

    // Resize ahead of the first register; bubbles and power-save carry a zero product.
    always_comb begin
        fits    = prod_fits(prod_x, P_W, signed_rng);
        in_prod = '0;
        in_ovf  = 1'b0;
        if (IN_VALID && USE_MULT) begin
            in_ovf = !fits;
            if (!fits && SAT != 0) begin
                in_prod = P_W'(sat_limit(prod_x[FULL_W-1], P_W, signed_rng));
            end else begin
                in_prod = prod_x[P_W-1:0];
            end
        end
    end

    logic [P_W-1:0] prod_c [PIPE_DEPTH+1];
    logic           ovf_c  [PIPE_DEPTH+1];
    logic           vld_c  [PIPE_DEPTH+1];

    assign prod_c[0] = in_prod;
    assign ovf_c[0]  = in_ovf;
    assign vld_c[0]  = IN_VALID;

    for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
        mult_pipe_stage #(
            .P_W (P_W)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .ce_i   (CEM),
            .prod_i (prod_c[k]),
            .ovf_i  (ovf_c[k]),
            .vld_i  (vld_c[k]),
            .prod_o (prod_c[k+1]),
            .ovf_o  (ovf_c[k+1]),
            .vld_o  (vld_c[k+1])
        );
    end

    assign M       = prod_c[PIPE_DEPTH];
    assign M_OVF   = ovf_c[PIPE_DEPTH];
    assign M_VALID = vld_c[PIPE_DEPTH];

endmodule

// File: tb/tb_mult_pipe.sv
// Bench for mult_pipe: directed vectors, a stall sequence, random traffic, reset flush.
// Five builds share one stimulus bus: N=0, N=2, N=4 (P_W=48) and N=1 P_W=32 with SAT=0/1.
module tb_mult_pipe;

    logic        clk = 1'b0;
    logic        tb_rst = 1'b1;
    logic        tb_cem = 1'b1;
    logic        tb_use = 1'b1;
    logic        tb_as = 1'b1;
    logic        tb_bs = 1'b1;
    logic        tb_vld = 1'b0;
    logic [24:0] tb_a = '0;
    logic [17:0] tb_b = '0;

    always #5 clk = ~clk;

    logic [47:0] m0, m2, m4;
    logic [31:0] ms0, ms1;
    logic v0, v2, v4, vs0, vs1, o0, o2, o4, os0, os1;

    mult_pipe #(.A_W(25), .B_W(18), .P_W(48), .PIPE_DEPTH(0), .SAT(0)) dut0 (
        .clk(clk), .rst(tb_rst), .CEM(tb_cem), .USE_MULT(tb_use), .A_SIGNED(tb_as),
        .B_SIGNED(tb_bs), .IN_VALID(tb_vld), .AMULT(tb_a), .BMULT(tb_b),
        .M(m0), .M_VALID(v0), .M_OVF(o0));
    mult_pipe #(.A_W(25), .B_W(18), .P_W(48), .PIPE_DEPTH(2), .SAT(0)) dut2 (
        .clk(clk), .rst(tb_rst), .CEM(tb_cem), .USE_MULT(tb_use), .A_SIGNED(tb_as),
        .B_SIGNED(tb_bs), .IN_VALID(tb_vld), .AMULT(tb_a), .BMULT(tb_b),
        .M(m2), .M_VALID(v2), .M_OVF(o2));
    mult_pipe #(.A_W(25), .B_W(18), .P_W(48), .PIPE_DEPTH(4), .SAT(0)) dut4 (
        .clk(clk), .rst(tb_rst), .CEM(tb_cem), .USE_MULT(tb_use), .A_SIGNED(tb_as),
        .B_SIGNED(tb_bs), .IN_VALID(tb_vld), .AMULT(tb_a), .BMULT(tb_b),
        .M(m4), .M_VALID(v4), .M_OVF(o4));
    mult_pipe #(.A_W(25), .B_W(18), .P_W(32), .PIPE_DEPTH(1), .SAT(0)) dut_s0 (
        .clk(clk), .rst(tb_rst), .CEM(tb_cem), .USE_MULT(tb_use), .A_SIGNED(tb_as),
        .B_SIGNED(tb_bs), .IN_VALID(tb_vld), .AMULT(tb_a), .BMULT(tb_b),
        .M(ms0), .M_VALID(vs0), .M_OVF(os0));
    mult_pipe #(.A_W(25), .B_W(18), .P_W(32), .PIPE_DEPTH(1), .SAT(1)) dut_s1 (
        .clk(clk), .rst(tb_rst), .CEM(tb_cem), .USE_MULT(tb_use), .A_SIGNED(tb_as),
        .B_SIGNED(tb_bs), .IN_VALID(tb_vld), .AMULT(tb_a), .BMULT(tb_b),
        .M(ms1), .M_VALID(vs1), .M_OVF(os1));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------------
    typedef struct {
        logic [47:0] m48;
        logic        o48;
        logic [31:0] m32n;
        logic [31:0] m32s;
        logic        o32;
        logic        vld;
    } rec_t;

    function automatic rec_t zero_rec();
        rec_t r;
        r.m48 = '0; r.o48 = 1'b0; r.m32n = '0; r.m32s = '0; r.o32 = 1'b0; r.vld = 1'b0;
        return r;
    endfunction

    function automatic void resz(input longint p, input int w, input bit sg, input bit sat,
                                 output logic [63:0] m, output bit ovf);
        longint lo, hi, mask;
        mask = (longint'(1) << w) - 1;
        if (sg) begin
            lo = -(longint'(1) << (w - 1));
            hi = (longint'(1) << (w - 1)) - 1;
        end else begin
            lo = 0;
            hi = mask;
        end
        ovf = (p < lo) || (p > hi);
        if (ovf && sat) m = sg ? ((p < 0) ? (longint'(1) << (w - 1)) : hi) : mask;
        else            m = p & mask;
    endfunction

    function automatic rec_t model(input logic [24:0] ai, input logic [17:0] bi,
                                   input bit as, input bit bs, input bit um, input bit vld);
        rec_t r;
        longint av, bv, p;
        logic [63:0] m;
        bit o, sg;
        r = zero_rec();
        r.vld = vld;
        if (vld && um) begin
            av = as ? longint'($signed(ai)) : longint'(ai);
            bv = bs ? longint'($signed(bi)) : longint'(bi);
            p  = av * bv;
            sg = as || bs;
            resz(p, 48, sg, 1'b0, m, o); r.m48  = m[47:0]; r.o48 = o;
            resz(p, 32, sg, 1'b0, m, o); r.m32n = m[31:0]; r.o32 = o;
            resz(p, 32, sg, 1'b1, m, o); r.m32s = m[31:0];
        end
        return r;
    endfunction

    // hist[k] = what was accepted k enabled edges ago; a depth-N build shows hist[N-1].
    rec_t hist [4];
    initial for (int i = 0; i < 4; i++) hist[i] = zero_rec();

    always @(posedge clk) begin
        if (tb_rst) begin
            for (int i = 0; i < 4; i++) hist[i] = zero_rec();
        end else if (tb_cem) begin
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = model(tb_a, tb_b, tb_as, tb_bs, tb_use, tb_vld);
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [24:0] a;
        logic [17:0] b;
        logic        as, bs, um;
        logic [47:0] e48;
        logic        o48;
        logic [31:0] e32n;
        logic [31:0] e32s;
        logic        o32;
    } vec_t;

    vec_t tbl [12];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin : main
        rec_t e;
        logic [47:0] got [$];
        logic [47:0] want [4];
        bit   cem_seq [12];
        int   a_seq   [12];

        tbl[0]  = '{25'h1FFFFFD, 18'h00005, 1, 1, 1, 48'hFFFF_FFFF_FFF1, 0, 32'hFFFF_FFF1, 32'hFFFF_FFF1, 0};
        tbl[1]  = '{25'h1FFFFFF, 18'h3FFFF, 0, 0, 1, 48'h07FF_FDFC_0001, 0, 32'hFDFC_0001, 32'hFFFF_FFFF, 1};
        tbl[2]  = '{25'h0100000, 18'h01000, 1, 1, 1, 48'h0001_0000_0000, 0, 32'h0000_0000, 32'h7FFF_FFFF, 1};
        tbl[3]  = '{25'h1F00000, 18'h01000, 1, 1, 1, 48'hFFFF_0000_0000, 0, 32'h0000_0000, 32'h8000_0000, 1};
        tbl[4]  = '{25'h0000064, 18'h00007, 1, 1, 0, 48'h0,             0, 32'h0,           32'h0,           0};
        tbl[5]  = '{25'h1FFFFFF, 18'h3FFFF, 1, 0, 1, 48'hFFFF_FFFC_0001, 0, 32'hFFFC_0001, 32'hFFFC_0001, 0};
        tbl[6]  = '{25'h0000064, 18'h3FFFE, 0, 1, 1, 48'hFFFF_FFFF_FF38, 0, 32'hFFFF_FF38, 32'hFFFF_FF38, 0};
        tbl[7]  = '{25'h0FFFFFF, 18'h20000, 1, 1, 1, 48'hFE00_0002_0000, 0, 32'h0002_0000, 32'h8000_0000, 1};
        tbl[8]  = '{25'h0010000, 18'h10000, 0, 0, 1, 48'h0001_0000_0000, 0, 32'h0000_0000, 32'hFFFF_FFFF, 1};
        tbl[9]  = '{25'h0010000, 18'h08000, 1, 1, 1, 48'h0000_8000_0000, 0, 32'h8000_0000, 32'h7FFF_FFFF, 1};
        tbl[10] = '{25'h0010000, 18'h08000, 0, 0, 1, 48'h0000_8000_0000, 0, 32'h8000_0000, 32'h8000_0000, 0};
        tbl[11] = '{25'h1FF0000, 18'h08000, 1, 1, 1, 48'hFFFF_8000_0000, 0, 32'h8000_0000, 32'h8000_0000, 0};

        // ---- reset state ----
        tick(); tick();
        chk("rst_m2", m2, 0); chk("rst_v2", v2, 0); chk("rst_o2", o2, 0);
        chk("rst_v4", v4, 0); chk("rst_vs1", vs1, 0);
        tb_rst = 1'b0;

        // ---- fill pipe, then reset while stalled ----
        tb_as = 1; tb_bs = 1; tb_use = 1; tb_vld = 1; tb_a = 25'd5; tb_b = 18'd3;
        tick(); tick();
        chk("fill_m2", m2, 15); chk("fill_v2", v2, 1);
        tb_cem = 0; tb_rst = 1;
        #1;
        chk("rst_comb_m0", m0, 15); chk("rst_comb_v0", v0, 1);
        tick();
        chk("rst_cem0_m2", m2, 0); chk("rst_cem0_v2", v2, 0); chk("rst_cem0_v4", v4, 0);
        tb_rst = 0; tb_cem = 1; tb_vld = 0;
        tick();

        // ---- table vectors ----
        for (int i = 0; i < 12; i++) begin
            tb_a = tbl[i].a; tb_b = tbl[i].b; tb_as = tbl[i].as; tb_bs = tbl[i].bs;
            tb_use = tbl[i].um; tb_vld = 1;
            #1;
            chk($sformatf("tbl%0d_m0", i), m0, tbl[i].e48);
            chk($sformatf("tbl%0d_o0", i), o0, tbl[i].o48);
            chk($sformatf("tbl%0d_v0", i), v0, 1);
            tick();
            chk($sformatf("tbl%0d_ms0", i), ms0, tbl[i].e32n);
            chk($sformatf("tbl%0d_os0", i), os0, tbl[i].o32);
            chk($sformatf("tbl%0d_ms1", i), ms1, tbl[i].e32s);
            chk($sformatf("tbl%0d_os1", i), os1, tbl[i].o32);
            tb_vld = 0;
            tick();
            chk($sformatf("tbl%0d_m2", i), m2, tbl[i].e48);
            chk($sformatf("tbl%0d_o2", i), o2, tbl[i].o48);
            chk($sformatf("tbl%0d_v2", i), v2, 1);
        end
        tick();
        chk("bubble_v2", v2, 0); chk("bubble_m2", m2, 0);

        // ---- back-to-back issue with a 3-cycle stall ----
        cem_seq = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        a_seq   = '{2, 3, 99, 99, 99, 4, 5, 0, 0, 0, 0, 0};
        want    = '{48'd6, 48'd9, 48'd12, 48'd15};
        tb_as = 1; tb_bs = 1; tb_use = 1; tb_b = 18'd3;
        for (int i = 0; i < 12; i++) begin
            tb_cem = cem_seq[i];
            tb_a   = 25'(a_seq[i]);
            tb_vld = (a_seq[i] != 0);
            tick();
            if (!cem_seq[i]) begin
                chk($sformatf("stall%0d_m2", i), m2, 6);
                chk($sformatf("stall%0d_v2", i), v2, 1);
            end else if (v2) begin
                got.push_back(m2);
            end
        end
        chk("stall_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_order%0d", i), (i < got.size()) ? got[i] : 48'hDEAD, want[i]);
        end

        // ---- random traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            tb_a   = 25'($urandom);
            tb_b   = 18'($urandom);
            tb_as  = 1'($urandom);
            tb_bs  = 1'($urandom);
            tb_use = ($urandom_range(0, 7) != 0);
            tb_vld = ($urandom_range(0, 3) != 0);
            tb_cem = ($urandom_range(0, 3) != 0);
            tb_rst = ($urandom_range(0, 63) == 0);
            if ((n % 8) == 0) begin
                // steer some operands to range edges
                tb_a = $urandom_range(0, 1) ? 25'h1000000 : 25'h0FFFFFF;
                tb_b = $urandom_range(0, 1) ? 18'h20000 : 18'h1FFFF;
            end
            #1;
            e = model(tb_a, tb_b, tb_as, tb_bs, tb_use, tb_vld);
            chk("rnd_m0", m0, e.m48); chk("rnd_o0", o0, e.o48); chk("rnd_v0", v0, e.vld);
            tick();
            chk("rnd_m2", m2, hist[1].m48); chk("rnd_o2", o2, hist[1].o48); chk("rnd_v2", v2, hist[1].vld);
            chk("rnd_m4", m4, hist[3].m48); chk("rnd_o4", o4, hist[3].o48); chk("rnd_v4", v4, hist[3].vld);
            chk("rnd_ms0", ms0, hist[0].m32n); chk("rnd_os0", os0, hist[0].o32); chk("rnd_vs0", vs0, hist[0].vld);
            chk("rnd_ms1", ms1, hist[0].m32s); chk("rnd_os1", os1, hist[0].o32); chk("rnd_vs1", vs1, hist[0].vld);
        end

        // ---- reset with three products in flight in the N=4 build ----
        tb_rst = 0; tb_cem = 1; tb_use = 1; tb_as = 0; tb_bs = 0; tb_vld = 1;
        tb_a = 25'd11; tb_b = 18'd13;
        tick(); tick(); tick();
        tb_rst = 1;
        tick();
        tb_rst = 0; tb_vld = 0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("flush%0d_v4", i), v4, 0);
            chk($sformatf("flush%0d_m4", i), m4, 0);
            tick();
        end
        // first valid after reset: exactly 4 enabled cycles
        tb_vld = 1;
        tick();
        tb_vld = 0;
        tick(); tick();
        chk("lat4_early_v4", v4, 0);
        tick();
        chk("lat4_v4", v4, 1); chk("lat4_m4", m4, 143);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
